// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU writeback sources and the regfile write port.
// Both requests use valid/ready: a transfer happens on any cycle where valid && ready; a
// requester keeps valid, wa and wd stable until it sees ready. ready never waits on itself.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_wa;
    logic [XLEN-1:0] alu_wd;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_wa;
    logic [XLEN-1:0] lsu_wd;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;

    modport master (
        output alu_valid, alu_wa, alu_wd, lsu_valid, lsu_wa, lsu_wd,
        input  alu_ready, lsu_ready, rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  alu_valid, alu_wa, alu_wd, lsu_valid, lsu_wa, lsu_wd,
        output alu_ready, lsu_ready, rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between ALU and LSU writebacks and tracks pending
// destinations for RAW hazard checks. Define WB_FIXED_PRIO_EN for fixed LSU>ALU priority.
module regfile_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        chk_rs1,
    input  logic [AW-1:0]        chk_rs2,
    output logic                 hazard,
    output logic [NREG-1:0]      busy_vec
);
    logic            alu_gnt;
    logic            lsu_gnt;
    logic            acc;
    logic            wr_en;
    logic [AW-1:0]   acc_wa;
    logic [XLEN-1:0] acc_wd;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_n;
    logic            rf_we_q;
    logic [AW-1:0]   rf_wa_q;
    logic [XLEN-1:0] rf_wd_q;

`ifndef WB_FIXED_PRIO_EN
    typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_e;
    grant_e last_grant;
`endif

    // Grants are forced low during reset so nothing is accepted while state is being cleared.
    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (!rst) begin
            if (wb.alu_valid && wb.lsu_valid) begin
`ifdef WB_FIXED_PRIO_EN
                lsu_gnt = 1'b1;
`else
                if (last_grant == GRANT_LSU) alu_gnt = 1'b1;
                else                         lsu_gnt = 1'b1;
`endif
            end else begin
                alu_gnt = wb.alu_valid;
                lsu_gnt = wb.lsu_valid;
            end
        end
    end

    assign acc    = alu_gnt || lsu_gnt;
    assign acc_wa = lsu_gnt ? wb.lsu_wa : wb.alu_wa;
    assign acc_wd = lsu_gnt ? wb.lsu_wd : wb.alu_wd;
    // x0 writes complete the handshake but never reach the regfile or the scoreboard.
    assign wr_en  = acc && (acc_wa != '0);

    // A new producer supersedes the retiring one, so the set is applied after the clear.
    always_comb begin
        busy_n = busy_q;
        if (wr_en) busy_n[acc_wa] = 1'b0;
        if (iss_valid && (iss_rd != '0)) busy_n[iss_rd] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            busy_q  <= '0;
        end else begin
            rf_we_q <= wr_en;
            if (wr_en) begin
                rf_wa_q <= acc_wa;
                rf_wd_q <= acc_wd;
            end
            busy_q <= busy_n;
        end
    end

`ifndef WB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_LSU;
        end else if (alu_gnt) begin
            last_grant <= GRANT_ALU;
        end else if (lsu_gnt) begin
            last_grant <= GRANT_LSU;
        end
    end
`endif

    assign wb.alu_ready = alu_gnt;
    assign wb.lsu_ready = lsu_gnt;
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_wa     = rf_wa_q;
    assign wb.rf_wd     = rf_wd_q;
    assign busy_vec     = busy_q;
    assign hazard       = ((chk_rs1 != '0) && busy_q[chk_rs1]) ||
                          ((chk_rs2 != '0) && busy_q[chk_rs2]);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a register-level model.
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        hazard;
  logic [31:0] busy_vec;

  regfile_wb_arbiter_if #(.XLEN(64), .AW(5)) wb();

  regfile_wb_arbiter #(.XLEN(64), .AW(5), .NREG(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .hazard    (hazard),
    .busy_vec  (busy_vec)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_busy[32];
  bit          m_alu_next;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [63:0] m_wd;
  logic [63:0] m_rf[32];
  logic [63:0] dut_rf[32];
  bit          a_hold;
  bit          l_hold;
  logic        last_ar;
  logic        last_lr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_alu_next = 1'b1;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic set_in(input bit av, input logic [4:0] awa, input logic [63:0] awd,
                        input bit lv, input logic [4:0] lwa, input logic [63:0] lwd,
                        input bit iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
    wb.alu_valid = av; wb.alu_wa = awa; wb.alu_wd = awd;
    wb.lsu_valid = lv; wb.lsu_wa = lwa; wb.lsu_wd = lwd;
    iss_valid = iv; iss_rd = ird; chk_rs1 = r1; chk_rs2 = r2;
  endtask

  task automatic idle();
    set_in(0, '0, '0, 0, '0, '0, 0, '0, '0, '0);
  endtask

  // One clock: check combinational outputs, cross the edge, advance the model, check registers.
  task automatic cycle();
    logic        exp_ar;
    logic        exp_lr;
    logic        exp_hz;
    logic [4:0]  wa;
    logic [63:0] wd;
    exp_ar = 1'b0;
    exp_lr = 1'b0;
    if (wb.alu_valid && wb.lsu_valid) begin
`ifdef WB_FIXED_PRIO_EN
      exp_lr = 1'b1;
`else
      if (m_alu_next) exp_ar = 1'b1;
      else            exp_lr = 1'b1;
`endif
    end else begin
      exp_ar = wb.alu_valid;
      exp_lr = wb.lsu_valid;
    end
    exp_hz = (chk_rs1 != 0 && m_busy[chk_rs1]) || (chk_rs2 != 0 && m_busy[chk_rs2]);
    #1;
    chk("alu_ready", {63'd0, wb.alu_ready}, {63'd0, exp_ar});
    chk("lsu_ready", {63'd0, wb.lsu_ready}, {63'd0, exp_lr});
    chk("hazard", {63'd0, hazard}, {63'd0, exp_hz});
    if (wb.rf_we) dut_rf[wb.rf_wa] = wb.rf_wd;
    a_hold = wb.alu_valid && !exp_ar;
    l_hold = wb.lsu_valid && !exp_lr;
    last_ar = exp_ar;
    last_lr = exp_lr;
    @(posedge clk);
    if (m_we) m_rf[m_wa] = m_wd;
    if (exp_ar || exp_lr) begin
      wa = exp_lr ? wb.lsu_wa : wb.alu_wa;
      wd = exp_lr ? wb.lsu_wd : wb.alu_wd;
      m_we = (wa != 0);
      if (m_we) begin
        m_wa = wa;
        m_wd = wd;
        m_busy[wa] = 1'b0;
      end
      m_alu_next = exp_lr;
    end else begin
      m_we = 1'b0;
    end
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    #1;
    chk("rf_we", {63'd0, wb.rf_we}, {63'd0, m_we});
    chk("rf_wa", {59'd0, wb.rf_wa}, {59'd0, m_wa});
    chk("rf_wd", wb.rf_wd, m_wd);
    chk("busy_vec", {32'd0, busy_vec}, {32'd0, model_busy_vec()});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      dut_rf[i] = '0;
    end
    model_reset();
    rst = 1'b1;
    idle();
    wb.alu_valid = 1'b1;
    wb.lsu_valid = 1'b1;
    #12;
    chk("rst_alu_ready", {63'd0, wb.alu_ready}, 64'd0);
    chk("rst_lsu_ready", {63'd0, wb.lsu_ready}, 64'd0);
    chk("rst_rf_we", {63'd0, wb.rf_we}, 64'd0);
    chk("rst_rf_wa", {59'd0, wb.rf_wa}, 64'd0);
    chk("rst_rf_wd", wb.rf_wd, 64'd0);
    chk("rst_busy", {32'd0, busy_vec}, 64'd0);
    idle();
    rst = 1'b0;

    // ALU only to x5
    set_in(1, 5'd5, 64'hA5A5A5A5A5A5A5A5, 0, '0, '0, 0, '0, '0, '0);
    cycle();
    chk("alu_only_ready", {63'd0, last_ar}, 64'd1);
    idle();
    cycle();
    chk("alu_only_we", {63'd0, wb.rf_we}, 64'd0);
    idle();
    cycle();
    chk("x5_read", dut_rf[5], 64'hA5A5A5A5A5A5A5A5);

    // scoreboard set, hazard, LSU clear of x7
    set_in(0, '0, '0, 0, '0, '0, 1, 5'd7, '0, '0);
    cycle();
    chk("busy7_set", {63'd0, busy_vec[7]}, 64'd1);
    set_in(0, '0, '0, 1, 5'd7, 64'hFFFFFFFFFFFFFFFF, 0, '0, 5'd7, '0);
    cycle();
    chk("hazard7", {63'd0, hazard}, 64'd0);
    chk("busy7_clr", {63'd0, busy_vec[7]}, 64'd0);
    set_in(0, '0, '0, 0, '0, '0, 0, '0, 5'd7, 5'd7);
    cycle();

    // tie: round-robin ALU,LSU,ALU (fixed: LSU x3)
    for (int k = 0; k < 3; k++) begin
      set_in(1, 5'd10, 64'h123456789ABCDEF0, 1, 5'd7, 64'hFFFFFFFFFFFFFFFF, 0, '0, '0, '0);
      cycle();
    end
    idle();
    cycle();

    // same-register set/clear: set wins; different registers: both apply
    set_in(0, '0, '0, 0, '0, '0, 1, 5'd9, '0, '0);
    cycle();
    set_in(1, 5'd9, 64'h0000000000000999, 0, '0, '0, 1, 5'd9, 5'd9, '0);
    cycle();
    chk("busy9_setwins", {63'd0, busy_vec[9]}, 64'd1);
    set_in(1, 5'd9, 64'h0000000000000099, 0, '0, '0, 1, 5'd3, '0, 5'd9);
    cycle();
    chk("busy3_set", {63'd0, busy_vec[3]}, 64'd1);
    chk("busy9_clr", {63'd0, busy_vec[9]}, 64'd0);

    // x0 handling
    set_in(0, '0, '0, 0, '0, '0, 1, 5'd0, '0, '0);
    cycle();
    set_in(1, 5'd0, 64'h00000000DEADBEEF, 0, '0, '0, 0, '0, 5'd0, 5'd0);
    cycle();
    chk("x0_we", {63'd0, wb.rf_we}, 64'd0);
    chk("busy0", {63'd0, busy_vec[0]}, 64'd0);
    idle();
    cycle();

    // random traffic; held requests keep wa/wd stable
    a_hold = 1'b0;
    l_hold = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!a_hold) begin
        wb.alu_valid = 1'($urandom_range(0, 1));
        wb.alu_wa = 5'($urandom_range(0, 31));
        wb.alu_wd = {$urandom, $urandom};
      end
      if (!l_hold) begin
        wb.lsu_valid = 1'($urandom_range(0, 1));
        wb.lsu_wa = 5'($urandom_range(0, 31));
        wb.lsu_wd = {$urandom, $urandom};
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd = 5'($urandom_range(0, 31));
      chk_rs1 = 5'($urandom_range(0, 31));
      chk_rs2 = 5'($urandom_range(0, 31));
      cycle();
    end
    idle();
    cycle();
    cycle();
    for (int i = 1; i < 32; i++) chk($sformatf("rf_x%0d", i), dut_rf[i], m_rf[i]);

    // reset during an accept of x12: write dropped, ALU wins the first tie afterwards
    set_in(0, '0, '0, 0, '0, '0, 1, 5'd4, '0, '0);
    cycle();
    set_in(1, 5'd12, 64'hC0FFEE0012121212, 0, '0, '0, 0, '0, '0, '0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_we", {63'd0, wb.rf_we}, 64'd0);
    chk("midrst_busy", {32'd0, busy_vec}, 64'd0);
    chk("midrst_ready", {63'd0, wb.alu_ready}, 64'd0);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
    cycle();
    chk("x12_kept", dut_rf[12], m_rf[12]);
    set_in(1, 5'd10, 64'h123456789ABCDEF0, 1, 5'd7, 64'hFFFFFFFFFFFFFFFF, 0, '0, '0, '0);
    cycle();
`ifndef WB_FIXED_PRIO_EN
    chk("post_rst_tie_alu", {63'd0, last_ar}, 64'd1);
`endif
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
